rv32_fetch_seq: RTL

Sequential fetch/issue stage that sits directly upstream of the combinational RV32 execute core. It owns the architectural PC, fetches one instruction word at a time over a valid/ready instruction bus, and presents it to the core as `pc`/`insn`/`insn_valid`. It advances the PC on the core's completion handshake and maintains the `cycle`/`instret` counters fed back to the core's CSR inputs. It halts permanently on trap.

---
 rtl/rv32_fetch_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rv32_fetch_seq.sv
// rv32_fetch_seq: sequential fetch/issue stage in front of a combinational
// RV32 execute core. Owns the architectural PC, fetches one word at a time,
// hands it to the core, advances on completion and keeps cycle/instret.
module rv32_fetch_seq #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic        insn_valid,
  input  logic        insn_complete,
  input  logic [31:0] pc_next,
  input  logic        pc_next_valid,
  input  logic        trap,
  output logic [63:0] csr_cycle,
  output logic [63:0] csr_instret,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   insn_load;
  logic   pc_load;
  logic   retire;

  // State register; reset parks the sequencer in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register-load strobes. Core handshake inputs only matter
  // in EXEC and the fetch accept only in FETCH.
  always_comb begin
    state_d   = state_q;
    insn_load = 1'b0;
    pc_load   = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          insn_load = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (insn_complete) begin
          if (trap) begin
            state_d = HALT;
          end else if (pc_next_valid) begin
            pc_load = 1'b1;
            retire  = 1'b1;
            // A misaligned target is never fetched; stop with the PC updated.
            state_d = (pc_next[1:0] != 2'b00) ? HALT : FETCH;
          end else begin
            // Completion without a final next PC is a core protocol error.
            state_d = HALT;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // PC and instruction registers; insn only changes on the fetch accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= PROGADDR_RESET;
      insn <= 32'h0000_0000;
    end else begin
      if (pc_load) begin
        pc <= pc_next;
      end
      if (insn_load) begin
        insn <= imem_rdata;
      end
    end
  end

  // CSR counters: cycle runs in every state but HALT; both wrap modulo 2^64.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_cycle   <= 64'd0;
      csr_instret <= 64'd0;
    end else begin
      if (state_q != HALT) begin
        csr_cycle <= csr_cycle + 64'd1;
      end
      if (retire) begin
        csr_instret <= csr_instret + 64'd1;
      end
    end
  end

  assign imem_valid = (state_q == FETCH);
  assign imem_addr  = pc;
  assign insn_valid = (state_q == EXEC);
  assign halted     = (state_q == HALT);

endmodule
